// File: rtl/crc4_bank_builder_if.sv
// crc4_bank_builder_if: word input handshake and parallel bank output bundle
// for crc4_bank_builder. The err_inject signal exists only when
// CRC4_ERR_INJECT_EN is defined.
interface crc4_bank_builder_if #(
   parameter int NSLOT = 16,
   parameter int DW    = 64,
   parameter int CW    = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DW-1:0]         in_data;
   logic                  bank_valid;
   logic                  bank_ack;
   logic [NSLOT*DW-1:0]   data_bus;
   logic [NSLOT*CW-1:0]   crc_bus;
   logic [4:0]            slot_count;
`ifdef CRC4_ERR_INJECT_EN
   logic                  err_inject;

   modport master (output in_valid, in_data, bank_ack, err_inject,
                   input  in_ready, bank_valid, data_bus, crc_bus, slot_count);
   modport slave  (input  in_valid, in_data, bank_ack, err_inject,
                   output in_ready, bank_valid, data_bus, crc_bus, slot_count);
`else
   modport master (output in_valid, in_data, bank_ack,
                   input  in_ready, bank_valid, data_bus, crc_bus, slot_count);
   modport slave  (input  in_valid, in_data, bank_ack,
                   output in_ready, bank_valid, data_bus, crc_bus, slot_count);
`endif
endinterface

// File: rtl/crc4_bank_builder.sv
// crc4_bank_builder: accepts 64-bit words, computes CRC-4 (x^4+x+1, init 0,
// MSB first) one nibble per cycle, and collects 16 word/CRC pairs into a
// bank that is presented in parallel until acknowledged.
// Optional feature: define CRC4_ERR_INJECT_EN to add err_inject, which
// inverts bit 0 of the stored CRC for the word accepted with it set.
module crc4_bank_builder #(
   parameter int NSLOT = 16,
   parameter int DW    = 64,
   parameter int CW    = 4
) (
   input  logic                clock,
   input  logic                reset,
   crc4_bank_builder_if.slave  bus
);

   localparam int              NIB       = 4;
   localparam int              NNIB      = DW / NIB;
   localparam logic [3:0]      LAST_NIB  = 4'(NNIB - 1);
   localparam logic [4:0]      LAST_SLOT = 5'(NSLOT - 1);
   localparam logic [CW-1:0]   POLY      = 4'h3;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FULL = 2'd2;

   logic [1:0]                 state;
   logic [DW-1:0]              shreg;
   logic [CW-1:0]              crc;
   logic [3:0]                 nib_cnt;
   logic [4:0]                 count;
   logic [NSLOT-1:0][DW-1:0]   data_q;
   logic [NSLOT-1:0][CW-1:0]   crc_q;
   logic [CW-1:0]              crc_next;
   logic [CW-1:0]              crc_store;
   logic [DW-1:0]              shreg_rot;

   // Fold one nibble into the CRC, MSB bit first.
   function automatic logic [CW-1:0] fold_nibble(input logic [CW-1:0] c,
                                                 input logic [NIB-1:0] nib);
      logic [CW-1:0] r;
      r = c;
      for (int b = NIB - 1; b >= 0; b--) begin
         if (r[CW-1] ^ nib[b])
            r = {r[CW-2:0], 1'b0} ^ POLY;
         else
            r = {r[CW-2:0], 1'b0};
      end
      return r;
   endfunction

   // The shift register rotates, so after the 16th nibble it holds the
   // original word again and can be stored directly.
   assign shreg_rot = {shreg[DW-NIB-1:0], shreg[DW-1 -: NIB]};
   assign crc_next  = fold_nibble(crc, shreg[DW-1 -: NIB]);

`ifdef CRC4_ERR_INJECT_EN
   logic err_q;
   assign crc_store = crc_next ^ {{(CW-1){1'b0}}, err_q};
`else
   assign crc_store = crc_next;
`endif

   assign bus.in_ready   = (state == IDLE) && !reset;
   assign bus.bank_valid = (state == FULL);
   assign bus.slot_count = count;
   assign bus.data_bus   = data_q;
   assign bus.crc_bus    = crc_q;

   // Control FSM, serial CRC datapath and bank storage.
   always_ff @(posedge clock) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (reset) begin
         state   <= IDLE;
         shreg   <= '0;
         crc     <= '0;
         nib_cnt <= '0;
         count   <= '0;
         // NOTE: the bank is cleared on reset because it is directly visible
         // on data_bus/crc_bus; a stale bank must never be observed.
         data_q  <= '0;
         crc_q   <= '0;
`ifdef CRC4_ERR_INJECT_EN
         err_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  shreg   <= bus.in_data;
                  crc     <= '0;
                  nib_cnt <= '0;
`ifdef CRC4_ERR_INJECT_EN
                  err_q   <= bus.err_inject;
`endif
                  state   <= CALC;
               end
            end
            CALC: begin
               crc     <= crc_next;
               shreg   <= shreg_rot;
               nib_cnt <= nib_cnt + 4'd1;
               if (nib_cnt == LAST_NIB) begin
                  data_q[count[3:0]] <= shreg_rot;
                  crc_q[count[3:0]]  <= crc_store;
                  count              <= count + 5'd1;
                  state              <= (count == LAST_SLOT) ? FULL : IDLE;
               end
            end
            FULL: begin
               if (bus.bank_ack) begin
                  count <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/crc4_bank_builder.md
# crc4_bank_builder

Upstream framing stage for the 16-channel CRC checker. Accepts 64-bit data words one at a time over a valid/ready handshake and computes a CRC-4 for each word serially, 4 bits per cycle. Stores each word and its CRC into a 16-slot bank. When all 16 slots are filled, it presents the whole bank in parallel as the checker's Data1..Data16 / CRC1..CRC16 inputs and holds it until acknowledged.

## Interface
Parameters:
- NSLOT, 16: number of bank slots; fixed at 16, because the checker has 16 channels.
- DW, 64: data word width.
- CW, 4: CRC width.

Ports:
- clock, in, 1: sole clock; all logic updates on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- in_valid, in, 1: in_data is valid this cycle.
- in_ready, out, 1: block can accept a word this cycle.
- in_data, in, 64: data word to frame.
- bank_valid, out, 1: bank is complete and stable on data_bus/crc_bus.
- bank_ack, in, 1: consumer has taken the bank; sampled only while bank_valid=1.
- data_bus, out, 1024: slot i occupies bits [64i+63:64i]; slot 0 maps to Data1, slot 15 maps to Data16.
- crc_bus, out, 64: slot i occupies bits [4i+3:4i]; slot 0 maps to CRC1.
- slot_count, out, 5: number of slots filled in the current bank (0..16).

## Operation
CRC definition:
- Polynomial x^4+x+1 (0x3).
- Initial value 0, MSB-first, no reflection, no final XOR.
- The result equals the remainder of in_data·x^4 mod P.

States:
- IDLE: in_ready=1. A handshake (in_valid & in_ready) latches in_data into a shift register, clears the CRC accumulator and nibble counter, and moves to CALC.
- CALC: each cycle folds one nibble into the CRC, MSB nibble ([63:60]) first, and increments the nibble counter (0..15).
  - On the cycle the 16th nibble is processed, the final CRC and the original word are written into slot slot_count, and slot_count increments.
  - If the new count is 16, next state is FULL; otherwise next state is IDLE.
- FULL: bank_valid=1 and in_ready=0. When bank_ack=1, slot_count clears to 0 and the next state is IDLE. data_bus/crc_bus keep their old contents until each slot is overwritten.

Rules:
- in_ready is 0 in CALC and FULL. in_valid while in_ready=0 is ignored; the source holds the word until it is accepted.
- bank_ack outside FULL has no effect.
- in_data is sampled only on the accept edge; later changes do not affect the word in flight.
- Arithmetic is modulo-2. The nibble counter wraps 15→0 only on slot write. slot_count never exceeds 16.

Reset (synchronous, any state):
- State goes to IDLE; slot_count, nibble counter and CRC accumulator go to 0.
- data_bus and crc_bus go to 0; bank_valid goes to 0.
- in_ready is 0 during any cycle with reset=1 and 1 in the first cycle after reset deasserts.
- A word in flight at reset is discarded; a partially filled bank is discarded.

## Timing
- Word accepted at edge T. CRC is complete and the slot written at edge T+16. in_ready=1 again in the cycle after T+16.
- Sustained throughput: one word per 17 cycles. A full bank takes 16×17 = 272 cycles from the first accept, given back-to-back input.
- bank_valid rises in the cycle after the 16th slot write.
- Acknowledge: with bank_ack=1 at edge A, bank_valid=0 and in_ready=1 in cycle A+1. The earliest new accept is at edge A+1.
- data_bus/crc_bus are registered outputs with no combinational path from inputs.

## Configuration
- CRC4_ERR_INJECT_EN defined:
  - Adds input err_inject (1 bit), sampled on the accept edge together with in_data.
  - If it was 1, bit 0 of that slot's stored CRC is inverted. This gives deliberate mismatches for exercising the downstream checker.
- CRC4_ERR_INJECT_EN undefined: the port does not exist, and stored CRCs are always correct.

## Test plan
- Reset, then words 0x1, 0x0, 0x2, 0x8000_0000_0000_0000, then 12× 0x0, then hold bank_ack=0 for 50 cycles.
  - Required: crc_bus slots 0..3 = 0x3, 0x0, 0x6, 0xB; slots 4..15 = 0x0.
  - Required: bank_valid holds steady with data_bus unchanged for all 50 cycles.
- Word accepted at T: in_ready=0 for T+1..T+16 and 1 at T+17.
  - Required: in_valid pulses in T+1..T+16 are not accepted and slot_count does not change.
- Bank full, assert bank_ack for one cycle.
  - Required: next cycle bank_valid=0, slot_count=0, in_ready=1.
  - Required: the next word 0x1 is written to slot 0 with CRC 0x3, and slots 1..15 are unchanged.
- Reset asserted mid-CALC with slot_count=5.
  - Required: the following cycle all buses are 0 and slot_count=0.
  - Required: the next accepted word lands in slot 0.
- With CRC4_ERR_INJECT_EN defined: word 0x1 with err_inject=1 → slot CRC 0x2; word 0x1 with err_inject=0 → 0x3.
